// File: rtl/ppu_mem_loader.sv
// ppu_mem_loader: copies LIST (addr,data) pairs or BLOCK ranges from a source memory
// into one of NUM_CH PPU RAM write ports; cmd in, src_* read side, wr_* write side, status out.
module ppu_mem_loader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int NUM_CH = 2,
  parameter int LEN_W  = 16,
  parameter int CH_W   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [CH_W-1:0]   chan,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic [ADDR_W-1:0] src_addr,
  output logic              src_rd_en,
  input  logic [ADDR_W-1:0] src_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [NUM_CH-1:0] wr_en,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [LEN_W-1:0]  count
);

  typedef enum logic [2:0] {
    IDLE, LIST_A, LIST_D, BLOCK_RD, DRAIN, FIN
  } state_t;

  localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);
  localparam logic [CH_W:0]     NCH = (CH_W+1)'(NUM_CH);

  state_t state, state_d;

  logic              mode_q;
  logic [CH_W-1:0]   chan_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem;
  logic              rd_dat;
  logic              pend;
  logic              pend_dat;
  logic              abt;

  logic accept, kill, issue, issue_dat;
  logic act, act_d, last, chan_ok, dec, wr_go;

  assign chan_ok = {1'b0, chan} < NCH;
  assign last    = (rem == LEN_W'(1));
  assign act     = (state == LIST_A) || (state == LIST_D) ||
                   (state == BLOCK_RD) || (state == DRAIN);
  assign act_d   = (state_d == LIST_A) || (state_d == LIST_D) ||
                   (state_d == BLOCK_RD) || (state_d == DRAIN);
  // rem counts LIST entries or BLOCK reads still to be issued
  assign dec     = issue && !accept && (mode_q || issue_dat);
  // the source word landing now is a write payload (every BLOCK word, LIST data words)
  assign wr_go   = pend && !kill && (mode_q || pend_dat);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d   = state;
    accept    = 1'b0;
    kill      = 1'b0;
    issue     = 1'b0;
    issue_dat = 1'b0;
    unique case (state)
      IDLE, FIN: begin
        state_d = IDLE;
        if (start && !abort) begin
          accept = 1'b1;
          if (len == '0 || !chan_ok) begin
            state_d = DRAIN;
          end else begin
            issue = 1'b1;
            if (!mode)                  state_d = LIST_D;
            else if (len == LEN_W'(1))  state_d = DRAIN;
            else                        state_d = BLOCK_RD;
          end
        end
      end
      LIST_A: begin
        issue   = 1'b1;
        state_d = LIST_D;
      end
      LIST_D: begin
        issue     = 1'b1;
        issue_dat = 1'b1;
        state_d   = last ? DRAIN : LIST_A;
      end
      BLOCK_RD: begin
        issue   = 1'b1;
        state_d = last ? DRAIN : BLOCK_RD;
      end
      DRAIN: begin
        if (!src_rd_en && !pend) state_d = FIN;
      end
      default: state_d = IDLE;
    endcase
    if (act && abort) begin
      kill      = 1'b1;
      issue     = 1'b0;
      issue_dat = 1'b0;
      state_d   = DRAIN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= 1'b0;
      chan_q    <= '0;
      dst_q     <= '0;
      ptr       <= '0;
      addr_q    <= '0;
      rem       <= '0;
      rd_dat    <= 1'b0;
      pend      <= 1'b0;
      pend_dat  <= 1'b0;
      abt       <= 1'b0;
      src_addr  <= '0;
      src_rd_en <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_en     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      count     <= '0;
    end else begin
      src_rd_en <= issue;
      rd_dat    <= issue_dat;
      pend      <= src_rd_en && !kill;
      pend_dat  <= rd_dat;
      done      <= (state_d == FIN);
      busy      <= act_d;
      wr_en     <= '0;
      if (accept) begin
        mode_q  <= mode;
        chan_q  <= chan;
        dst_q   <= dst_base;
        ptr     <= src_base + ADDR_W'(1);
        rem     <= mode ? len - LEN_W'(1) : len;
        count   <= '0;
        aborted <= 1'b0;
        abt     <= !chan_ok;
      end
      if (issue) src_addr <= accept ? src_base : ptr;
      if (issue && !accept) ptr <= ptr + ADDR_W'(1);
      if (dec) rem <= rem - LEN_W'(1);
      if (pend && !pend_dat && !mode_q && !kill) addr_q <= src_data;
      if (wr_go) begin
        wr_en   <= ONE << chan_q;
        wr_data <= src_data[DATA_W-1:0];
        wr_addr <= mode_q ? dst_q : addr_q;
        count   <= count + LEN_W'(1);
        if (mode_q) dst_q <= dst_q + ADDR_W'(1);
      end
      if (kill) abt <= 1'b1;
      if (state_d == FIN && abt) aborted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ppu_mem_loader.sv
// tb_ppu_mem_loader: randomized self-checking bench for ppu_mem_loader
// against a transaction-level model of LIST/BLOCK copies and their timing.
module tb_ppu_mem_loader;

  typedef struct packed {
    logic [15:0] t;
    logic [1:0]  en;
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        start1 = 1'b0;
  logic        mode = 1'b0;
  logic [0:0]  chan = '0;
  logic [15:0] src_base = '0;
  logic [15:0] dst_base = '0;
  logic [15:0] len = '0;
  logic        abort = 1'b0;
  logic [15:0] src_data = '0;

  logic [15:0] src_addr, wr_addr, count;
  logic        src_rd_en, busy, done, aborted;
  logic [7:0]  wr_data;
  logic [1:0]  wr_en;

  logic [15:0] src_addr1, wr_addr1, count1;
  logic        src_rd_en1, busy1, done1, aborted1;
  logic [7:0]  wr_data1;
  logic [0:0]  wr_en1;

  logic [15:0] mem [0:65535];
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  wr_t         obs_wr[$];
  wr_t         exp_wr[$];
  logic [15:0] obs_rd[$];
  int          obs_done;
  int          exp_done;
  logic [15:0] obs_cnt;
  logic        obs_abt;
  int          e0;

  ppu_mem_loader dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .chan(chan),
    .src_base(src_base), .dst_base(dst_base), .len(len), .abort(abort),
    .src_addr(src_addr), .src_rd_en(src_rd_en), .src_data(src_data),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .busy(busy),
    .done(done), .aborted(aborted), .count(count)
  );

  ppu_mem_loader #(.NUM_CH(1), .CH_W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode), .chan(chan),
    .src_base(src_base), .dst_base(dst_base), .len(len), .abort(abort),
    .src_addr(src_addr1), .src_rd_en(src_rd_en1), .src_data(src_data),
    .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_en(wr_en1), .busy(busy1),
    .done(done1), .aborted(aborted1), .count(count1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (src_rd_en) src_data <= mem[src_addr];

  task automatic model_cmd(input logic m, input logic c,
                           input logic [15:0] sb, input logic [15:0] db,
                           input logic [15:0] ln);
    logic [15:0] s;
    logic [1:0]  en;
    wr_t w;
    en = c ? 2'b10 : 2'b01;
    exp_wr.delete();
    for (int k = 0; k < int'(ln); k++) begin
      if (!m) begin
        s = sb + 16'(2 * k);
        w.a = mem[s];
        s = s + 16'd1;
        w.d = mem[s][7:0];
        w.t = 16'(2 * k + 3);
      end else begin
        s = sb + 16'(k);
        w.a = db + 16'(k);
        w.d = mem[s][7:0];
        w.t = 16'(k + 2);
      end
      w.en = en;
      exp_wr.push_back(w);
    end
    exp_done = (ln == 0) ? 1 : (m ? int'(ln) + 2 : 2 * int'(ln) + 2);
  endtask

  task automatic run_cmd(input logic m, input logic c,
                         input logic [15:0] sb, input logic [15:0] db,
                         input logic [15:0] ln,
                         input int abort_at, input int restart_at);
    int t;
    int budget;
    obs_wr.delete();
    obs_rd.delete();
    obs_done = -1;
    obs_cnt = 'x;
    obs_abt = 1'bx;
    @(negedge clk);
    mode = m; chan = c; src_base = sb; dst_base = db; len = ln;
    start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    start = 1'b0;
    budget = 2 * int'(ln) + 30;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      t = cyc - e0;
      if (wr_en != 0) obs_wr.push_back({16'(t), wr_en, wr_addr, wr_data});
      if (src_rd_en) obs_rd.push_back(src_addr);
      if (done) begin
        obs_done = t;
        obs_cnt = count;
        obs_abt = aborted;
        break;
      end
      if (t == abort_at) begin
        abort = 1'b1;
        start = 1'b1;
      end else if (t == abort_at + 1) begin
        abort = 1'b0;
        start = 1'b0;
      end
      if (t == restart_at) begin
        start = 1'b1;
        mode = ~m;
        src_base = sb + 16'h0040;
        dst_base = ~db;
        len = 16'd1;
      end else if (t == restart_at + 1) begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({src_addr, src_rd_en, wr_addr, wr_data, wr_en, busy, done, aborted, count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got addr=%h rd=%b wa=%h wd=%h en=%b busy=%b done=%b abt=%b cnt=%0d exp all 0",
               src_addr, src_rd_en, wr_addr, wr_data, wr_en, busy, done, aborted, count);
    end
    checks++;
    if ({src_rd_en1, wr_en1, busy1, done1, aborted1, count1, wr_addr1, wr_data1, src_addr1} !== '0) begin
      failures++;
      $display("FAIL reset_outputs_dut1 got nonzero exp all 0");
    end
  endtask

  task automatic test_list_plan;
    mem[16'h0100] = 16'h2000; mem[16'h0101] = 16'h0011;
    mem[16'h0102] = 16'h23C0; mem[16'h0103] = 16'h0022;
    mem[16'h0104] = 16'h3F00; mem[16'h0105] = 16'h000F;
    model_cmd(1'b0, 1'b0, 16'h0100, 16'h0000, 16'd3);
    run_cmd(1'b0, 1'b0, 16'h0100, 16'h0000, 16'd3, -10, -10);
    checks++;
    if (obs_wr.size() != exp_wr.size()) begin
      failures++;
      $display("FAIL list_nwr got=%0d exp=%0d", obs_wr.size(), exp_wr.size());
    end
    foreach (exp_wr[k]) if (k < obs_wr.size()) begin
      checks++;
      if (obs_wr[k] !== exp_wr[k]) begin
        failures++;
        $display("FAIL list_wr%0d got=%h exp=%h", k, obs_wr[k], exp_wr[k]);
      end
    end
    checks++;
    if (obs_done !== 8 || obs_cnt !== 16'd3 || obs_abt !== 1'b0) begin
      failures++;
      $display("FAIL list_end got done_t=%0d cnt=%0d abt=%b exp 8 3 0", obs_done, obs_cnt, obs_abt);
    end
  endtask

  task automatic test_block_plan;
    model_cmd(1'b1, 1'b1, 16'h0200, 16'h0000, 16'd256);
    run_cmd(1'b1, 1'b1, 16'h0200, 16'h0000, 16'd256, -10, -10);
    checks++;
    if (obs_wr.size() != exp_wr.size()) begin
      failures++;
      $display("FAIL block_nwr got=%0d exp=%0d", obs_wr.size(), exp_wr.size());
    end
    foreach (exp_wr[k]) if (k < obs_wr.size()) begin
      checks++;
      if (obs_wr[k] !== exp_wr[k]) begin
        failures++;
        $display("FAIL block_wr%0d got=%h exp=%h", k, obs_wr[k], exp_wr[k]);
      end
    end
    checks++;
    if (obs_done !== 258 || obs_cnt !== 16'd256 || obs_abt !== 1'b0) begin
      failures++;
      $display("FAIL block_end got done_t=%0d cnt=%0d abt=%b exp 258 256 0", obs_done, obs_cnt, obs_abt);
    end
  endtask

  task automatic test_wrap;
    model_cmd(1'b1, 1'b0, 16'hFFFE, 16'hFFFF, 16'd4);
    run_cmd(1'b1, 1'b0, 16'hFFFE, 16'hFFFF, 16'd4, -10, -10);
    checks++;
    if (obs_rd.size() != 4) begin
      failures++;
      $display("FAIL wrap_nrd got=%0d exp=4", obs_rd.size());
    end
    foreach (obs_rd[k]) begin
      checks++;
      if (obs_rd[k] !== 16'hFFFE + 16'(k)) begin
        failures++;
        $display("FAIL wrap_rd%0d got=%h exp=%h", k, obs_rd[k], 16'hFFFE + 16'(k));
      end
    end
    checks++;
    if (obs_wr.size() != exp_wr.size()) begin
      failures++;
      $display("FAIL wrap_nwr got=%0d exp=%0d", obs_wr.size(), exp_wr.size());
    end
    foreach (exp_wr[k]) if (k < obs_wr.size()) begin
      checks++;
      if (obs_wr[k] !== exp_wr[k]) begin
        failures++;
        $display("FAIL wrap_wr%0d got=%h exp=%h", k, obs_wr[k], exp_wr[k]);
      end
    end
    checks++;
    if (obs_done !== exp_done) begin
      failures++;
      $display("FAIL wrap_done got=%0d exp=%0d", obs_done, exp_done);
    end
  endtask

  task automatic test_random;
    logic        m, c;
    logic [15:0] sb, db, ln;
    for (int n = 0; n < 8; n++) begin
      m  = 1'($urandom_range(0, 1));
      c  = 1'($urandom_range(0, 1));
      sb = 16'($urandom);
      db = 16'($urandom);
      ln = 16'($urandom_range(1, 12));
      model_cmd(m, c, sb, db, ln);
      run_cmd(m, c, sb, db, ln, -10, -10);
      checks++;
      if (obs_wr.size() != exp_wr.size()) begin
        failures++;
        $display("FAIL rand%0d_nwr got=%0d exp=%0d", n, obs_wr.size(), exp_wr.size());
      end
      foreach (exp_wr[k]) if (k < obs_wr.size()) begin
        checks++;
        if (obs_wr[k] !== exp_wr[k]) begin
          failures++;
          $display("FAIL rand%0d_wr%0d got=%h exp=%h", n, k, obs_wr[k], exp_wr[k]);
        end
      end
      checks++;
      if (obs_done !== exp_done || obs_cnt !== ln) begin
        failures++;
        $display("FAIL rand%0d_end got done_t=%0d cnt=%0d exp %0d %0d", n, obs_done, obs_cnt, exp_done, ln);
      end
    end
  endtask

  task automatic test_abort;
    model_cmd(1'b1, 1'b0, 16'h1000, 16'h0400, 16'd100);
    run_cmd(1'b1, 1'b0, 16'h1000, 16'h0400, 16'd100, 10, -10);
    checks++;
    if (obs_wr.size() != 9) begin
      failures++;
      $display("FAIL abort_nwr got=%0d exp=9", obs_wr.size());
    end
    foreach (obs_wr[k]) begin
      checks++;
      if (obs_wr[k] !== exp_wr[k]) begin
        failures++;
        $display("FAIL abort_wr%0d got=%h exp=%h", k, obs_wr[k], exp_wr[k]);
      end
    end
    checks++;
    if (obs_done !== 12 || obs_abt !== 1'b1 || obs_cnt !== 16'd9) begin
      failures++;
      $display("FAIL abort_end got done_t=%0d abt=%b cnt=%0d exp 12 1 9", obs_done, obs_abt, obs_cnt);
    end
  endtask

  task automatic test_idle_abort;
    logic bad;
    bad = 1'b0;
    @(negedge clk);
    mode = 1'b1; chan = 1'b0; len = 16'd4; src_base = 16'h0300;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (busy || done || src_rd_en || wr_en != 0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL idle_abort_start got activity=%b exp=0", bad);
    end
  endtask

  task automatic test_edges;
    logic bad;
    int   t;
    logic abt;
    run_cmd(1'b1, 1'b0, 16'h0500, 16'h0000, 16'd0, -10, -10);
    checks++;
    if (obs_done !== 1 || obs_rd.size() != 0 || obs_wr.size() != 0 || obs_cnt !== 16'd0) begin
      failures++;
      $display("FAIL len0 got done_t=%0d nrd=%0d nwr=%0d cnt=%0d exp 1 0 0 0",
               obs_done, obs_rd.size(), obs_wr.size(), obs_cnt);
    end
    bad = 1'b0;
    t = -1;
    abt = 1'b0;
    @(negedge clk);
    mode = 1'b1; chan = 1'b1; len = 16'd5; src_base = 16'h0600;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    start1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (src_rd_en1 || wr_en1 != 0) bad = 1'b1;
      if (done1) begin
        t = cyc - e0;
        abt = aborted1;
        break;
      end
    end
    checks++;
    if (t !== 1 || abt !== 1'b1 || bad !== 1'b0) begin
      failures++;
      $display("FAIL bad_chan got done_t=%0d abt=%b activity=%b exp 1 1 0", t, abt, bad);
    end
    model_cmd(1'b1, 1'b1, 16'h0700, 16'h0080, 16'd8);
    run_cmd(1'b1, 1'b1, 16'h0700, 16'h0080, 16'd8, -10, 3);
    checks++;
    if (obs_wr.size() != exp_wr.size()) begin
      failures++;
      $display("FAIL busy_start_nwr got=%0d exp=%0d", obs_wr.size(), exp_wr.size());
    end
    foreach (exp_wr[k]) if (k < obs_wr.size()) begin
      checks++;
      if (obs_wr[k] !== exp_wr[k]) begin
        failures++;
        $display("FAIL busy_start_wr%0d got=%h exp=%h", k, obs_wr[k], exp_wr[k]);
      end
    end
    checks++;
    if (obs_done !== exp_done || obs_cnt !== 16'd8) begin
      failures++;
      $display("FAIL busy_start_end got done_t=%0d cnt=%0d exp %0d 8", obs_done, obs_cnt, exp_done);
    end
  endtask

  task automatic test_mid_reset;
    int   n;
    logic bad;
    n = 0;
    bad = 1'b0;
    @(negedge clk);
    mode = 1'b0; chan = 1'b0; len = 16'd4; src_base = 16'h0800;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (wr_en != 0) n++;
      if (n == 2) break;
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({src_addr, src_rd_en, wr_addr, wr_data, wr_en, busy, done, aborted, count} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs got rd=%b en=%b busy=%b cnt=%0d exp all 0 (writes seen %0d)",
               src_rd_en, wr_en, busy, count, n);
    end
    repeat (3) begin
      @(negedge clk);
      if (wr_en != 0 || src_rd_en) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_quiet got activity=%b exp=0", bad);
    end
    rst = 1'b1;
    model_cmd(1'b0, 1'b1, 16'h0900, 16'h0000, 16'd3);
    run_cmd(1'b0, 1'b1, 16'h0900, 16'h0000, 16'd3, -10, -10);
    checks++;
    if (obs_wr.size() != exp_wr.size()) begin
      failures++;
      $display("FAIL post_reset_nwr got=%0d exp=%0d", obs_wr.size(), exp_wr.size());
    end
    foreach (exp_wr[k]) if (k < obs_wr.size()) begin
      checks++;
      if (obs_wr[k] !== exp_wr[k]) begin
        failures++;
        $display("FAIL post_reset_wr%0d got=%h exp=%h", k, obs_wr[k], exp_wr[k]);
      end
    end
    checks++;
    if (obs_done !== exp_done || obs_cnt !== 16'd3 || obs_abt !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_end got done_t=%0d cnt=%0d abt=%b exp %0d 3 0",
               obs_done, obs_cnt, obs_abt, exp_done);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    test_list_plan();
    test_block_plan();
    test_wrap();
    test_random();
    test_abort();
    test_idle_abort();
    test_edges();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
